// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU MEM stage has fixed priority over the debug/loader
// port; a starvation counter forces one debug grant, and out-of-range addresses
// are granted without strobing the memory.
module dmem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_err,
    output logic          mem_write,
    output logic          mem_read,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned   CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_next;
    logic          force_gnt;
    logic          cpu_sel;
    logic          dbg_sel;
    logic          cpu_in_range;
    logic          dbg_in_range;
    logic          sel_we;
    logic          sel_in_range;
    logic          any_sel;

    // Grant decision; everything is suppressed while reset is held low
    always_comb begin
        cpu_in_range = (cpu_addr < DEPTH_A);
        dbg_in_range = (dbg_addr < DEPTH_A);
        force_gnt    = rst_n && dbg_req && (wait_cnt == LIMIT);
        cpu_sel      = rst_n && cpu_req && !force_gnt;
        dbg_sel      = rst_n && dbg_req && (!cpu_req || force_gnt);
        dbg_gnt      = dbg_sel;
        cpu_stall    = rst_n && cpu_req && force_gnt;
        cpu_rdata    = (cpu_sel && cpu_in_range && !cpu_we) ? mem_rdata : '0;
    end

    // Memory port mux: the selected requester drives address and data, idle drives zero
    always_comb begin
        mem_addr     = '0;
        mem_wdata    = '0;
        sel_we       = 1'b0;
        sel_in_range = 1'b0;
        any_sel      = cpu_sel || dbg_sel;
        if (cpu_sel) begin
            mem_addr     = cpu_addr;
            mem_wdata    = cpu_wdata;
            sel_we       = cpu_we;
            sel_in_range = cpu_in_range;
        end else if (dbg_sel) begin
            mem_addr     = dbg_addr;
            mem_wdata    = dbg_wdata;
            sel_we       = dbg_we;
            sel_in_range = dbg_in_range;
        end
        mem_write = any_sel && sel_we && sel_in_range;
        mem_read  = any_sel && !sel_we && sel_in_range;
    end

    // Starvation counter: counts cycles a debug request has waited, saturating at the limit
    always_comb begin
        wait_cnt_next = '0;
        if (dbg_req && !dbg_sel) begin
            if (wait_cnt >= LIMIT) begin
                wait_cnt_next = LIMIT;
            end else begin
                wait_cnt_next = wait_cnt + CW'(1);
            end
        end
    end

    // Counter and debug response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
            dbg_err    <= 1'b0;
        end else begin
            wait_cnt   <= wait_cnt_next;
            dbg_rvalid <= dbg_sel && !dbg_we;
            dbg_rdata  <= (dbg_sel && !dbg_we && dbg_in_range) ? mem_rdata : '0;
            if (dbg_sel) begin
                dbg_err <= !dbg_in_range;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a cycle-level reference model predicts every
// output; a monitor on the falling edge pops the predictions and compares.
module tb_dmem_arbiter;

    localparam int STARVE = 4;
    localparam int DEPTH  = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] env_mem [DEPTH] = '{default: 32'h0};
    logic [31:0] ref_mem [DEPTH];

    typedef struct {
        int          cyc;
        bit          rst;
        bit          cpu_stall;
        logic [31:0] cpu_rdata;
        bit          dbg_gnt;
        bit          dbg_rvalid;
        logic [31:0] dbg_rdata;
        bit          dbg_err;
        bit          mem_write;
        bit          mem_read;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } exp_t;

    exp_t exp_q[$];

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          wcnt   = 0;
    bit          m_rvalid = 0;
    logic [31:0] m_rdata  = 0;
    bit          m_err    = 0;

    dmem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .dbg_err    (dbg_err),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory: combinational read, write at the rising edge
    assign mem_rdata = (mem_addr < 32'(DEPTH)) ? env_mem[mem_addr[5:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_write && mem_addr < 32'(DEPTH)) env_mem[mem_addr[5:0]] <= mem_wdata;
    end

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, act, exp);
    endtask

    // Apply one cycle of stimulus, predict its outputs, advance the model
    task automatic drive(input bit r, input bit cr, input bit cw, input logic [31:0] ca,
                         input logic [31:0] cwd, input bit dr, input bit dw,
                         input logic [31:0] da, input logic [31:0] dwd, output bit granted);
        exp_t        e;
        bit          forced, cg, dg, we, in_r;
        logic [31:0] addr, wdata;
        @(posedge clk);
        #1;
        rst_n = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cwd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dwd;

        // Debug wins only if CPU is idle, or debug has waited the full limit
        forced = r && dr && (wcnt == STARVE);
        cg     = r && cr && !forced;
        dg     = r && dr && (!cr || forced);
        addr = 0; wdata = 0; we = 0;
        if (cg) begin addr = ca; wdata = cwd; we = cw; end
        else if (dg) begin addr = da; wdata = dwd; we = dw; end
        in_r = (addr < 32'(DEPTH));

        e.cyc        = cyc;
        e.rst        = r;
        e.cpu_stall  = r && cr && forced;
        e.dbg_gnt    = dg;
        e.cpu_rdata  = (cg && !cw && ca < 32'(DEPTH)) ? ref_mem[ca[5:0]] : 32'h0;
        e.mem_write  = (cg || dg) && we && in_r;
        e.mem_read   = (cg || dg) && !we && in_r;
        e.mem_addr   = addr;
        e.mem_wdata  = wdata;
        e.dbg_rvalid = m_rvalid;
        e.dbg_rdata  = m_rdata;
        e.dbg_err    = m_err;
        exp_q.push_back(e);

        if (!r) begin
            wcnt = 0; m_rvalid = 0; m_rdata = 0; m_err = 0;
        end else begin
            m_rvalid = dg && !dw;
            m_rdata  = (dg && !dw && da < 32'(DEPTH)) ? ref_mem[da[5:0]] : 32'h0;
            if (dg) m_err = !(da < 32'(DEPTH));
            if (!dr || dg) wcnt = 0;
            else wcnt = (wcnt + 1 > STARVE) ? STARVE : wcnt + 1;
            if (e.mem_write) ref_mem[addr[5:0]] = wdata;
        end
        granted = dg;
        cyc++;
    endtask

    // Monitor: compares every predicted cycle on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cpu_stall",  e.cyc, 32'(cpu_stall),  32'(e.cpu_stall));
                chk("cpu_rdata",  e.cyc, cpu_rdata,       e.cpu_rdata);
                chk("dbg_gnt",    e.cyc, 32'(dbg_gnt),    32'(e.dbg_gnt));
                chk("dbg_rvalid", e.cyc, 32'(dbg_rvalid), 32'(e.dbg_rvalid));
                chk("dbg_err",    e.cyc, 32'(dbg_err),    32'(e.dbg_err));
                chk("mem_write",  e.cyc, 32'(mem_write),  32'(e.mem_write));
                chk("mem_read",   e.cyc, 32'(mem_read),   32'(e.mem_read));
                if (e.dbg_rvalid) chk("dbg_rdata", e.cyc, dbg_rdata, e.dbg_rdata);
                if (e.rst) begin
                    chk("mem_addr",  e.cyc, mem_addr,  e.mem_addr);
                    chk("mem_wdata", e.cyc, mem_wdata, e.mem_wdata);
                end
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        int r = int'($urandom_range(0, 15));
        if (r == 0) return 32'($urandom_range(64, 300));
        if (r == 1) return $urandom;
        if (r < 8)  return 32'($urandom_range(0, 7));
        return 32'($urandom_range(0, 63));
    endfunction

    initial begin
        bit          g;
        bit          d_pend;
        bit          d_we;
        logic [31:0] d_addr, d_wdata;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        rst_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;

        // Reset held with both requests asserted
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 5, 0, 1, 0, 3, 0, g);
        drive(1, 0, 0, 0, 0, 1, 0, 3, 0, g);

        // CPU only: write then read, and a debug read right after a CPU write
        drive(1, 1, 1, 5, 12, 0, 0, 0, 0, g);
        drive(1, 1, 0, 5, 0, 0, 0, 0, 0, g);
        drive(1, 1, 1, 9, 77, 0, 0, 0, 0, g);
        drive(1, 0, 0, 0, 0, 1, 0, 9, 0, g);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // Debug only: preload addr 17 then read it back
        drive(1, 0, 0, 0, 0, 1, 1, 17, 100, g);
        drive(1, 0, 0, 0, 0, 1, 0, 17, 0, g);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // Starvation: CPU busy every cycle, debug read held until granted
        g = 0;
        for (int i = 0; i < 8; i++) begin
            if (!g) drive(1, 1, 0, 32'(i), 0, 1, 0, 5, 0, g);
            else    drive(1, 1, 0, 32'(i), 0, 0, 0, 0, 0, g);
        end

        // Out of range: debug write at DEPTH, CPU read far outside
        drive(1, 0, 0, 0, 0, 1, 1, 64, 55, g);
        drive(1, 1, 0, 200, 0, 0, 0, 0, 0, g);
        drive(1, 0, 0, 0, 0, 1, 0, 5, 0, g);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // Reset while the debug request has waited three cycles
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 0, 1, 0, 9, 0, g);
        drive(0, 1, 0, 1, 0, 1, 0, 9, 0, g);
        g = 0;
        for (int i = 0; i < 7; i++) begin
            if (!g) drive(1, 1, 0, 2, 0, 1, 0, 9, 0, g);
            else    drive(1, 1, 0, 2, 0, 0, 0, 0, 0, g);
        end

        // Random traffic; debug requests stay stable until granted
        d_pend = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, cr, cw;
            logic [31:0] ca, cwd;
            r   = ($urandom_range(0, 49) != 0);
            cr  = ($urandom_range(0, 3) != 0);
            cw  = $urandom_range(0, 1) == 1;
            ca  = rand_addr();
            cwd = $urandom;
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend  = 1;
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = rand_addr();
                d_wdata = $urandom;
            end
            drive(r, cr, cw, ca, cwd, d_pend, d_we, d_pend ? d_addr : 32'h0,
                  d_pend ? d_wdata : 32'h0, g);
            if (g) d_pend = 0;
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, g);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", cyc, 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
